// File: rtl/scan_decoder_if.sv
// Bus bundle for scan_decoder: enables, mode/select controls and decoded outputs.
interface scan_decoder_if #(
    parameter int SEL_W = 3,
    parameter int DIV_W = 16
);
    localparam int N = 1 << SEL_W;

    logic             g1;
    logic             g2a_n;
    logic             g2b_n;
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] scan_last;
    logic [DIV_W-1:0] div;
    logic [N-1:0]     y;
    logic [SEL_W-1:0] cur_sel;
    logic             tick;

    modport master (
        output g1, g2a_n, g2b_n, mode, sel, scan_last, div,
        input  y, cur_sel, tick
    );

    modport slave (
        input  g1, g2a_n, g2b_n, mode, sel, scan_last, div,
        output y, cur_sel, tick
    );
endinterface

// File: rtl/scan_decoder.sv
// Registered N-to-2^N line decoder with 74LS138-style enables and an
// auto-scan mode that steps the active line through 0..scan_last.
module scan_decoder #(
    parameter int SEL_W      = 3,
    parameter int DIV_W      = 16,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    scan_decoder_if.slave bus
);
    localparam int N = 1 << SEL_W;
    localparam logic [N-1:0] Y_IDLE = {N{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        IDLE,
        MANUAL,
        SCAN
    } state_t;

    state_t           state;
    logic [N-1:0]     y_q;
    logic [SEL_W-1:0] cur_q;
    logic             tick_q;
    logic [DIV_W-1:0] count;
    logic             en;
    logic [SEL_W-1:0] next_idx;

    function automatic logic [N-1:0] decode(input logic [SEL_W-1:0] idx);
        logic [N-1:0] onehot;
        onehot      = '0;
        onehot[idx] = 1'b1;
        return ACTIVE_LOW ? ~onehot : onehot;
    endfunction

    // Combined enable and the wrap-aware successor of the held index.
    always_comb begin
        en       = bus.g1 & ~bus.g2a_n & ~bus.g2b_n;
        next_idx = (cur_q >= bus.scan_last) ? '0 : cur_q + 1'b1;
    end

    // Mode FSM; every output is registered at the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            y_q    <= Y_IDLE;
            cur_q  <= '0;
            tick_q <= 1'b0;
            count  <= '0;
        end else if (!en) begin
            state  <= IDLE;
            y_q    <= Y_IDLE;
            tick_q <= 1'b0;
            count  <= '0;
        end else if (!bus.mode) begin
            state  <= MANUAL;
            cur_q  <= bus.sel;
            y_q    <= decode(bus.sel);
            tick_q <= 1'b0;
            count  <= '0;
        end else begin
            state <= SCAN;
            if (state != SCAN) begin
                // Entry edge starts a fresh dwell on the held index.
                y_q    <= decode(cur_q);
                tick_q <= 1'b0;
                count  <= '0;
            end else if (count >= bus.div) begin
                // >= also catches div lowered below the running count.
                cur_q  <= next_idx;
                y_q    <= decode(next_idx);
                tick_q <= 1'b1;
                count  <= '0;
            end else begin
                y_q    <= decode(cur_q);
                tick_q <= 1'b0;
                count  <= count + 1'b1;
            end
        end
    end

    // Drive the bus outputs from the registered state.
    always_comb begin
        bus.y       = y_q;
        bus.cur_sel = cur_q;
        bus.tick    = tick_q;
    end
endmodule
